// File: rtl/fs_pkg.sv
// Shared types and constants for the full-subtractor block and its self-test.
package fs_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } bist_state_t;

  // Expected {D,Bout} per vector {X,Y,Bin}; element 0 is the rightmost entry.
  localparam logic [7:0][1:0] EXP_TBL = {
    2'b11,  // 111
    2'b00,  // 110
    2'b00,  // 101
    2'b10,  // 100
    2'b01,  // 011
    2'b11,  // 010
    2'b11,  // 001
    2'b00   // 000
  };

endpackage

// File: rtl/fs_core.sv
// Full subtractor from two half-subtractor stages and an OR.
// Purely combinational: zero latency, no flow control.
module fs_core (
  input  logic x,
  input  logic y,
  input  logic bin,
  output logic d,
  output logic bout
);

  logic hd1;
  logic x_n;
  logic hd1_n;
  logic hb1;
  logic hb2;

  // Difference path: two cascaded half-subtractor XORs.
  assign hd1 = x ^ y;
  assign d   = hd1 ^ bin;

  // Borrow path: each stage borrows on ~a & b, and either borrow propagates.
  not g_xn  (x_n, x);
  not g_hdn (hd1_n, hd1);
  and g_hb1 (hb1, x_n, y);
  and g_hb2 (hb2, hd1_n, bin);
  or  g_bo  (bout, hb1, hb2);

endmodule

// File: rtl/fs_mixed.sv
// Full subtractor with a registered copy and an exhaustive built-in self-test.
// D/Bout are combinational, D_r/Bout_r lag by one cycle; no backpressure.
module fs_mixed
  import fs_pkg::*;
#(
  parameter int unsigned BIST_DWELL = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic X,
  input  logic Y,
  input  logic Bin,
  output logic D,
  output logic Bout,
  output logic D_r,
  output logic Bout_r,
  input  logic bist_start,
  output logic bist_busy,
  output logic bist_done,
  output logic bist_fail
);

  localparam logic [3:0] DWELL_LAST = 4'(BIST_DWELL - 1);

  bist_state_t state;
  logic [2:0]  vec;
  logic [3:0]  dwell;
  logic        bist_d;
  logic        bist_bout;

  fs_core u_func_core (
    .x    (X),
    .y    (Y),
    .bin  (Bin),
    .d    (D),
    .bout (Bout)
  );

  // Separate instance so the self-test never disturbs the functional outputs.
  fs_core u_bist_core (
    .x    (vec[2]),
    .y    (vec[1]),
    .bin  (vec[0]),
    .d    (bist_d),
    .bout (bist_bout)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      D_r    <= 1'b0;
      Bout_r <= 1'b0;
    end else begin
      D_r    <= D;
      Bout_r <= Bout;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      vec       <= 3'd0;
      dwell     <= 4'd0;
      bist_busy <= 1'b0;
      bist_done <= 1'b0;
      bist_fail <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (bist_start) begin
            state     <= RUN;
            vec       <= 3'd0;
            dwell     <= 4'd0;
            bist_busy <= 1'b1;
            bist_done <= 1'b0;
            bist_fail <= 1'b0;
          end
        end
        RUN: begin
          // Compare only in the last dwell cycle of each vector.
          if (dwell == DWELL_LAST) begin
            dwell <= 4'd0;
            if ({bist_d, bist_bout} != EXP_TBL[vec]) begin
              bist_fail <= 1'b1;
            end
            if (vec == 3'd7) begin
              state     <= DONE;
              bist_busy <= 1'b0;
              bist_done <= 1'b1;
            end else begin
              vec <= vec + 3'd1;
            end
          end else begin
            dwell <= dwell + 4'd1;
          end
        end
        default: begin
          state     <= IDLE;
          bist_busy <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fs_mixed.sv
// Directed bench for fs_mixed: truth table, registered path, self-test at two dwells.
module tb_fs_mixed;
  import fs_pkg::*;

  logic clk = 1'b0;
  logic rst;
  logic X, Y, Bin;
  logic start1, start3;

  logic d1, bo1, dr1, bor1, busy1, done1, fail1;
  logic d3, bo3, dr3, bor3, busy3, done3, fail3;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  fs_mixed #(.BIST_DWELL(1)) dut (
    .clk(clk), .rst(rst), .X(X), .Y(Y), .Bin(Bin),
    .D(d1), .Bout(bo1), .D_r(dr1), .Bout_r(bor1),
    .bist_start(start1), .bist_busy(busy1), .bist_done(done1), .bist_fail(fail1)
  );

  fs_mixed #(.BIST_DWELL(3)) dut3 (
    .clk(clk), .rst(rst), .X(X), .Y(Y), .Bin(Bin),
    .D(d3), .Bout(bo3), .D_r(dr3), .Bout_r(bor3),
    .bist_start(start3), .bist_busy(busy3), .bist_done(done3), .bist_fail(fail3)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Pulses start on one instance and counts busy cycles (bounded).
  task automatic run_bist(input bit which3, input int ignore_at, output int cnt);
    @(negedge clk);
    if (which3) start3 = 1'b1; else start1 = 1'b1;
    @(negedge clk);
    start1 = 1'b0;
    start3 = 1'b0;
    cnt = 0;
    while ((which3 ? busy3 : busy1) && cnt < 100) begin
      cnt++;
      if (which3) start3 = (cnt == ignore_at);
      @(negedge clk);
    end
    start3 = 1'b0;
  endtask

  // Hand-written {D,Bout} for {X,Y,Bin} = 0..7.
  logic [1:0] exp_tt [8] = '{2'b00, 2'b11, 2'b11, 2'b01, 2'b10, 2'b00, 2'b00, 2'b11};

  initial begin
    int n;
    logic [2:0] v;
    rst = 1'b1; X = 0; Y = 0; Bin = 0; start1 = 0; start3 = 0;
    #2;
    check("rst_dr",    dr1,   0);
    check("rst_bor",   bor1,  0);
    check("rst_busy",  busy1, 0);
    check("rst_done",  done1, 0);
    check("rst_fail",  fail1, 0);
    check("rst_state", 32'(dut.state), 32'(IDLE));
    // Combinational path stays live under reset.
    {X, Y, Bin} = 3'b011; #1;
    check("rst_comb", {d1, bo1}, 2'b01);

    // Exhaustive combinational sweep, 5 ns apart.
    for (int i = 0; i < 8; i++) begin
      v = 3'(i);
      {X, Y, Bin} = v;
      #1;
      check($sformatf("comb_%0d", i), {d1, bo1}, exp_tt[i]);
      check($sformatf("comb3_%0d", i), {d3, bo3}, exp_tt[i]);
      #4;
    end

    @(negedge clk);
    rst = 1'b0;
    {X, Y, Bin} = 3'b000;
    @(negedge clk);
    {X, Y, Bin} = 3'b001;
    #1;
    check("reg_before", {dr1, bor1}, 2'b00);
    @(posedge clk); #1;
    check("reg_after_001", {dr1, bor1}, 2'b11);
    @(negedge clk); {X, Y, Bin} = 3'b100;
    @(posedge clk); #1;
    check("reg_after_100", {dr1, bor1}, 2'b10);
    @(negedge clk); {X, Y, Bin} = 3'b110;
    @(posedge clk); #1;
    check("reg_after_110", {dr3, bor3}, 2'b00);

    // Self-test, dwell 1.
    run_bist(1'b0, 0, n);
    check("bist1_busy_cycles", n, 8);
    check("bist1_done", done1, 1);
    check("bist1_fail", fail1, 0);

    // Self-test, dwell 3, with a start pulse mid-run that must be ignored.
    run_bist(1'b1, 10, n);
    check("bist3_busy_cycles", n, 24);
    check("bist3_done", done3, 1);
    check("bist3_fail", fail3, 0);

    // Restart from DONE clears done.
    @(negedge clk); start1 = 1'b1;
    @(negedge clk); start1 = 1'b0;
    check("restart_done_clr", done1, 0);
    check("restart_busy", busy1, 1);
    n = 0;
    while (busy1 && n < 100) begin n++; @(negedge clk); end
    check("restart_done", done1, 1);

    // Reset in the 4th RUN cycle aborts the test.
    {X, Y, Bin} = 3'b001;
    @(negedge clk); start1 = 1'b1;
    @(negedge clk); start1 = 1'b0;
    repeat (3) @(negedge clk);
    check("pre_abort_busy", busy1, 1);
    rst = 1'b1; #1;
    check("abort_busy",  busy1, 0);
    check("abort_done",  done1, 0);
    check("abort_fail",  fail1, 0);
    check("abort_dr",    {dr1, bor1}, 2'b00);
    check("abort_state", 32'(dut.state), 32'(IDLE));
    check("abort_vec",   dut.vec, 0);
    @(negedge clk); rst = 1'b0;
    run_bist(1'b0, 0, n);
    check("post_abort_cycles", n, 8);
    check("post_abort_done", done1, 1);
    check("post_abort_fail", fail1, 0);

    // Fault on the self-test borrow output.
    force dut.bist_bout = 1'b0;
    {X, Y, Bin} = 3'b010;
    run_bist(1'b0, 0, n);
    check("fault_func_bout", {d1, bo1}, 2'b11);
    check("fault_done", done1, 1);
    check("fault_fail", fail1, 1);
    release dut.bist_bout;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
